// File: rtl/pixel_fb_pkg.sv
// Shared FSM encoding, address helper and counter width for the pixel frame buffer.
package pixel_fb_pkg;

    localparam int unsigned OOB_BITS = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // Row-major linear pixel index; callers truncate to their address width.
    function automatic int unsigned coord_to_addr(input int unsigned x,
                                                  input int unsigned y,
                                                  input int unsigned width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/pixel_fb_ram.sv
// Simple dual-port pixel store: one write port, registered read that yields 0 when not enabled.
module pixel_fb_ram #(
    parameter int unsigned DEPTH     = 307200,
    parameter int unsigned ADDR_BITS = 19,
    parameter int unsigned DATA_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-first: a same-edge write to rd_addr is not visible until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/pixel_framebuffer.sv
// Frame store with 2-cycle scan-out read, bounds-checked write port and a full-frame clear engine.
// Define DOUBLE_BUFFER_EN for front/back stores with swap_req-controlled front_sel.
module pixel_framebuffer
    import pixel_fb_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned COLOR_BITS   = 4,
    parameter int unsigned COORD_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COORD_BITS-1:0] rd_x,
    input  logic [COORD_BITS-1:0] rd_y,
    output logic [COLOR_BITS-1:0] rd_color,
    input  logic [COORD_BITS-1:0] wr_x,
    input  logic [COORD_BITS-1:0] wr_y,
    input  logic [COLOR_BITS-1:0] wr_color,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  clear_start,
    input  logic [COLOR_BITS-1:0] clear_color,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [OOB_BITS-1:0]   oob_count,
    input  logic                  swap_req,
    output logic                  front_sel
);

    localparam int unsigned PIXELS    = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int unsigned ADDR_BITS = $clog2(PIXELS);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXELS - 1);

    fb_state_e             state, state_d;
    logic                  clr_load, clr_last;
    logic [ADDR_BITS-1:0]  clr_addr;
    logic [COLOR_BITS-1:0] clr_color;
    logic [ADDR_BITS-1:0]  rd_addr, rd_addr_s1, wr_addr, mem_addr;
    logic                  rd_inb, rd_inb_s1, wr_inb, wr_fire, mem_we;
    logic [COLOR_BITS-1:0] mem_data;

    assign rd_inb  = (32'(rd_x) < FRAME_WIDTH) && (32'(rd_y) < FRAME_HEIGHT);
    assign wr_inb  = (32'(wr_x) < FRAME_WIDTH) && (32'(wr_y) < FRAME_HEIGHT);
    assign rd_addr = ADDR_BITS'(coord_to_addr(32'(rd_x), 32'(rd_y), FRAME_WIDTH));
    assign wr_addr = ADDR_BITS'(coord_to_addr(32'(wr_x), 32'(wr_y), FRAME_WIDTH));

    // Clear always wins over a simultaneous write; the producer holds until IDLE.
    assign wr_ready = (state == IDLE) && !clear_start;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_d  = state;
        clr_load = 1'b0;
        clr_last = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    clr_load = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    clr_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_d;
            clear_busy <= (state_d == CLEAR);
            clear_done <= clr_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr  <= '0;
            clr_color <= '0;
        end else if (clr_load) begin
            clr_addr  <= '0;
            clr_color <= clear_color;
        end else if (state == CLEAR) begin
            clr_addr  <= clr_addr + ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_count <= '0;
        end else if (wr_fire && !wr_inb && (oob_count != '1)) begin
            oob_count <= oob_count + OOB_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_s1 <= '0;
            rd_inb_s1  <= 1'b0;
        end else begin
            rd_addr_s1 <= rd_addr;
            rd_inb_s1  <= rd_inb;
        end
    end

    always_comb begin
        mem_we   = wr_fire && wr_inb;
        mem_addr = wr_addr;
        mem_data = wr_color;
        if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
            mem_data = clr_color;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic                  swap_pending, rd_buf_s1;
    logic [COLOR_BITS-1:0] rd_data0, rd_data1;

    // Swaps requested mid-clear wait until the engine is back in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            rd_buf_s1    <= 1'b0;
        end else begin
            rd_buf_s1 <= front_sel;
            if (state == CLEAR) begin
                if (swap_req) begin
                    swap_pending <= 1'b1;
                end
            end else if (swap_req || swap_pending) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
            end
        end
    end

    pixel_fb_ram #(.DEPTH(PIXELS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(COLOR_BITS)) u_ram0 (
        .clk(clk), .reset_n(reset_n),
        .wr_en(mem_we && front_sel), .wr_addr(mem_addr), .wr_data(mem_data),
        .rd_en(rd_inb_s1 && !rd_buf_s1), .rd_addr(rd_addr_s1), .rd_data(rd_data0)
    );

    pixel_fb_ram #(.DEPTH(PIXELS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(COLOR_BITS)) u_ram1 (
        .clk(clk), .reset_n(reset_n),
        .wr_en(mem_we && !front_sel), .wr_addr(mem_addr), .wr_data(mem_data),
        .rd_en(rd_inb_s1 && rd_buf_s1), .rd_addr(rd_addr_s1), .rd_data(rd_data1)
    );

    // The disabled store always returns zero, so OR merges the two read ports.
    assign rd_color = rd_data0 | rd_data1;
`else
    logic unused_swap;

    assign unused_swap = swap_req;
    assign front_sel   = 1'b0;

    pixel_fb_ram #(.DEPTH(PIXELS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(COLOR_BITS)) u_ram (
        .clk(clk), .reset_n(reset_n),
        .wr_en(mem_we), .wr_addr(mem_addr), .wr_data(mem_data),
        .rd_en(rd_inb_s1), .rd_addr(rd_addr_s1), .rd_data(rd_color)
    );
`endif

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Bench for pixel_framebuffer on an 8x4 frame: read expectations flow through a scoreboard queue.
module tb_pixel_framebuffer;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  rd_x, rd_y, wr_x, wr_y;
    logic [3:0]  rd_color, wr_color, clear_color;
    logic        wr_valid, wr_ready, clear_start, clear_busy, clear_done;
    logic        swap_req, front_sel;
    logic [15:0] oob_count;

    int total = 0;
    int bad   = 0;
    int done_n;

    typedef struct {
        logic [3:0] color;
        int         x;
        int         y;
    } rd_exp_t;

    rd_exp_t    sb[$];
    rd_exp_t    mon_e;
    logic       rd_issue = 1'b0;
    logic       iss_now  = 1'b0;
    logic       iss_prev = 1'b0;
    logic [3:0] model [W*H];

    pixel_framebuffer #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COLOR_BITS(4), .COORD_BITS(10)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .oob_count(oob_count), .swap_req(swap_req), .front_sel(front_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] px(input int x, input int y);
        if (x >= W || y >= H) return 4'h0;
        return model[y*W + x];
    endfunction

    // Read data is due on the second rising edge after the address was presented.
    always @(posedge clk) begin
        iss_now = rd_issue;
        #1;
        if (iss_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_scoreboard: got read data 0x%0h with no expectation queued", rd_color);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("rd(%0d,%0d)", mon_e.x, mon_e.y), 32'(rd_color), 32'(mon_e.color));
            end
        end
        iss_prev = iss_now;
    end

    task automatic rd(input int x, input int y, input logic [3:0] e);
        rd_x     = 10'(x);
        rd_y     = 10'(y);
        rd_issue = 1'b1;
        sb.push_back('{e, x, y});
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input logic [3:0] c);
        bit acc = 1'b0;
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_color = c;
        wr_valid = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            #1;
            acc = wr_ready;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check($sformatf("wr_accept(%0d,%0d)", x, y), 32'(acc), 1);
        if (acc && x < W && y < H) model[y*W + x] = c;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    // Runs one full clear; optionally holds a colliding write or pokes clear_start mid-clear.
    task automatic do_clear(input logic [3:0] c, input bit with_wr, input bit poke);
        int busy_n   = 0;
        int dn       = 0;
        int done_at  = -1;
        int ready_at = -1;
        clear_start = 1'b1;
        clear_color = c;
        if (with_wr) begin
            wr_x = 10'd1; wr_y = 10'd1; wr_color = 4'hE; wr_valid = 1'b1;
        end
        #1;
        check("wr_ready_during_clear_start", 32'(wr_ready), 0);
        @(negedge clk);
        clear_start = 1'b0;
        clear_color = 4'h0;
        for (int i = 0; i < 40; i++) begin
            if (ready_at >= 0) wr_valid = 1'b0;
            #1;
            if (clear_busy) busy_n++;
            if (clear_done) begin
                dn++;
                done_at = i;
            end
            if (wr_ready && ready_at < 0) ready_at = i;
            clear_start = poke && (i == 5);
            clear_color = (poke && i == 5) ? 4'h7 : 4'h0;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("clear_busy_cycles", busy_n, 32);
        check("clear_done_pulses", dn, 1);
        check("clear_done_cycle", done_at, 32);
        check("wr_ready_first_after_clear", ready_at, 32);
        for (int a = 0; a < W*H; a++) model[a] = c;
        if (with_wr) model[9] = 4'hE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_color = '0;
        wr_valid = 1'b0; clear_start = 1'b0; clear_color = '0; swap_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rd_color", 32'(rd_color), 0);
        check("reset_clear_busy", 32'(clear_busy), 0);
        check("reset_clear_done", 32'(clear_done), 0);
        check("reset_oob_count", 32'(oob_count), 0);
        check("reset_front_sel", 32'(front_sel), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_wr_ready", 32'(wr_ready), 1);

        wr(3, 2, 4'hA);
        rd(3, 2, 4'hA);

        wr(8, 0, 4'h1);
        wr(0, 4, 4'h2);
        #1;
        check("oob_count_two", 32'(oob_count), 2);
        rd(8, 0, 4'h0);
        rd(3, 2, 4'hA);

        wr(7, 3, 4'hC);
        wr(0, 0, 4'hB);
        rd(7, 3, 4'hC);
        rd(0, 0, 4'hB);

        // Overwrite (7,3) on the same edge its pending read accesses memory: old value expected.
        rd_x = 10'd7; rd_y = 10'd3; rd_issue = 1'b1;
        sb.push_back('{4'hC, 7, 3});
        @(negedge clk);
        rd_issue = 1'b0;
        wr_x = 10'd7; wr_y = 10'd3; wr_color = 4'hD; wr_valid = 1'b1;
        #1;
        check("wr_ready_read_first", 32'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b0;
        model[31] = 4'hD;
        rd(7, 3, 4'hD);

        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        #1;
        check("front_sel_tied_low", 32'(front_sel), 0);
        rd(3, 2, 4'hA);
        drain();

        do_clear(4'h5, 1'b0, 1'b1);
        for (int a = 0; a < W*H; a++) rd(a % W, a / W, 4'h5);
        drain();

        do_clear(4'h6, 1'b1, 1'b0);
        rd(1, 1, 4'hE);
        rd(0, 0, 4'h6);
        rd(7, 3, 4'h6);
        drain();

        // Abort a clear after pixels 0..9 have been written.
        clear_start = 1'b1;
        clear_color = 4'h9;
        @(negedge clk);
        clear_start = 1'b0;
        clear_color = 4'h0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_clear_busy", 32'(clear_busy), 0);
        check("abort_clear_done", 32'(clear_done), 0);
        check("abort_oob_count", 32'(oob_count), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (clear_done) done_n++;
        end
        check("abort_no_clear_done", done_n, 0);
        check("abort_idle_busy", 32'(clear_busy), 0);
        for (int a = 0; a < 10; a++) model[a] = 4'h9;
        for (int a = 0; a < 12; a++) rd(a % W, a / W, px(a % W, a / W));
        drain();

        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
